// File: rtl/priority_scan_encoder_if.sv
// priority_scan_encoder_if: handshake bundle for the priority scan encoder.
// Ports: in_valid/in_ready/din (vector capture), out_valid/out_ready/qout/out_last (index stream).
// master = producer/consumer side, slave = encoder side.
interface priority_scan_encoder_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] din;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] qout;
    logic         out_last;

    modport master (
        output in_valid,
        output din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  qout,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output qout,
        output out_last
    );
endinterface

// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder: captures an N-bit request vector, then streams the
// index of every set bit, highest first, one per accepted output transfer.
// Ports: clk, nrst (sync active-low), bus (slave modport of
// priority_scan_encoder_if), busy, and pop_count (W+1 bits) only when the
// PSE_POPCOUNT_EN macro is defined.
module priority_scan_encoder #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    priority_scan_encoder_if.slave  bus,
    output logic                    busy
`ifdef PSE_POPCOUNT_EN
    ,
    output logic [$clog2(N):0]      pop_count
`endif
);
    localparam int W = $clog2(N);

    generate
        if (N < 4 || (1 << W) != N) begin : g_bad_n
            $error("priority_scan_encoder: N must be a power of two >= 4");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t       state;
    logic [N-1:0] pending;

    logic [W-1:0] top_idx;
    logic [N-1:0] top_mask;
    logic         single;
    logic         scanning;
    logic         xfer;

    // Ascending loop: the last set bit seen is the highest one.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i]) begin
                top_idx = W'(i);
            end
        end
    end

    assign top_mask = N'(1) << top_idx;

    // Exactly one bit set: non-zero and a power of two.
    assign single = (pending != '0) &&
                    ((pending & (pending - N'(1))) == '0);

    assign scanning = (state == SCAN);
    assign xfer     = scanning & bus.out_ready;

    // Outputs depend only on registers (and nrst, which forces them low).
    assign bus.in_ready  = nrst & ~scanning;
    assign bus.out_valid = nrst & scanning;
    assign bus.qout      = bus.out_valid ? top_idx : '0;
    assign bus.out_last  = bus.out_valid & single;
    assign busy          = nrst & scanning;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            pending <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A zero vector is accepted and dropped.
                    if (bus.in_valid && bus.din != '0) begin
                        pending <= bus.din;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (xfer) begin
                        pending <= pending & ~top_mask;
                        if (single) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef PSE_POPCOUNT_EN
    function automatic logic [W:0] count_ones(input logic [N-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pop_count <= '0;
        end else if (!scanning) begin
            if (bus.in_valid && bus.din != '0) begin
                pop_count <= count_ones(bus.din);
            end
        end else if (xfer) begin
            pop_count <= pop_count - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_priority_scan_encoder.sv
// tb_priority_scan_encoder: directed and random vectors checked against an
// index-queue reference model built from the set bits of each vector.
module tb_priority_scan_encoder;
    localparam int N = 8;
    localparam int W = 3;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic busy;
`ifdef PSE_POPCOUNT_EN
    logic [W:0] pop_count;
`endif

    priority_scan_encoder_if #(.N(N)) bus();

    priority_scan_encoder #(.N(N)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .bus      (bus),
        .busy     (busy)
`ifdef PSE_POPCOUNT_EN
        ,
        .pop_count(pop_count)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [N-1:0] v);
        exp_q.delete();
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) exp_q.push_back(i);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_qout"}, bus.qout, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
`ifdef PSE_POPCOUNT_EN
        chk({tag, "_pop_count"}, pop_count, 0);
`endif
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic capture(input logic [N-1:0] v, input bit noise);
        bus.in_valid = 1'b1;
        bus.din = v;
        @(negedge clk);
        chk("cap_in_ready", bus.in_ready, 1);
        chk("cap_out_valid", bus.out_valid, 0);
        @(posedge clk);
        build(v);
        #1;
        bus.in_valid = noise && (v != '0);
        bus.din = bus.in_valid ? '1 : '0;
    endtask

    // mode 0: ready always; 1: random ready; 2: ready from patt, then 1.
    task automatic drain(input int mode, input logic [15:0] patt,
                         input int max_xfers, input bit noise);
        int cyc;
        int n;
        cyc = 0;
        n = 0;
        while (exp_q.size() > 0 && n < max_xfers) begin
            if (cyc >= 200) begin
                compared++;
                mismatched++;
                $error("FAIL drain_timeout: observed %0d left expected 0",
                       exp_q.size());
                break;
            end
            case (mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = (cyc < 16) ? patt[cyc] : 1'b1;
            endcase
            if (noise && cyc > 0) begin
                bus.in_valid = 1'($urandom_range(0, 1));
                bus.din = N'($urandom);
            end
            @(negedge clk);
            chk("scan_out_valid", bus.out_valid, 1);
            chk("scan_qout", bus.qout, exp_q[0]);
            chk("scan_out_last", bus.out_last, exp_q.size() == 1);
            chk("scan_in_ready", bus.in_ready, 0);
            chk("scan_busy", busy, 1);
`ifdef PSE_POPCOUNT_EN
            chk("scan_pop_count", pop_count, exp_q.size());
`endif
            @(posedge clk);
            if (bus.out_ready) begin
                void'(exp_q.pop_front());
                n++;
            end
            #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.din = '0;
    endtask

    task automatic run(input logic [N-1:0] v, input int mode,
                       input logic [15:0] patt, input bit noise);
        capture(v, noise);
        drain(mode, patt, 1000, noise);
        @(negedge clk);
        check_idle("post");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v;
        bus.in_valid = 1'b0;
        bus.din = '0;
        bus.out_ready = 1'b0;

        // Reset held low: all outputs low.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_qout", bus.qout, 0);
        chk("rst_out_last", bus.out_last, 0);
`ifdef PSE_POPCOUNT_EN
        chk("rst_pop_count", pop_count, 0);
`endif
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        check_idle("rst_rel");
        @(posedge clk);
        #1;

        // Directed vectors.
        run(8'b1010_0100, 0, 16'h0, 1'b0);
        run(8'h00, 0, 16'h0, 1'b0);
        run(8'h90, 2, 16'b0000_0000_0001_0100, 1'b0);
        run(8'hFF, 0, 16'h0, 1'b0);

        // Reset mid-scan after index 3 is emitted.
        capture(8'h0F, 1'b0);
        drain(0, 16'h0, 1, 1'b0);
        nrst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_qout", bus.qout, 0);
        chk("mid_rst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle("after_rst");
        @(posedge clk);
        #1;
        run(8'h01, 0, 16'h0, 1'b0);

        // Input driven during scan is ignored.
        run(8'h41, 0, 16'h0, 1'b1);

        // Random vectors, random back-pressure, random input noise.
        for (int k = 0; k < 40; k++) begin
            v = N'($urandom);
            if (k % 5 == 0) v = '0;
            run(v, 1, 16'h0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule

// File: doc/priority_scan_encoder.md
# priority_scan_encoder

Parametrised sequential successor to the fixed 4-to-2 gate-level encoder. It captures an N-bit request vector through a valid/ready handshake, then emits the binary index of every set bit, highest index first, one per accepted output transfer. It sits between request-collecting logic and a downstream consumer that handles one index at a time (e.g. an interrupt or grant sequencer).

## Interface
- `N`, default 8: request vector width; power of two, N >= 4.
- `W`, default $clog2(N): index width. Localparam, not overridable.
- `clk` input 1: single clock; all state changes on its rising edge.
- `nrst` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: `din` is valid.
- `in_ready` output 1: block can accept a vector.
- `din` input N: request vector; bit i means request i.
- `out_valid` output 1: `qout` holds a valid index.
- `out_ready` input 1: consumer accepts `qout`.
- `qout` output W: binary index of the highest pending request.
- `out_last` output 1: `qout` is the final index of the current vector.
- `busy` output 1: a vector is being scanned.
- `pop_count` output W+1: only with `PSE_POPCOUNT_EN`; see Configuration.

## Operation
- Two states: IDLE and SCAN. Internal `pending` register, N bits.
- Reset (`nrst`=0 at an edge): state IDLE, `pending`=0, `pop_count`=0.
- While `nrst` is low: `in_ready`=0, `out_valid`=0, `qout`=0, `out_last`=0, `busy`=0.
- IDLE:
  - `in_ready`=1, `out_valid`=0, `busy`=0, `qout`=0, `out_last`=0.
  - `in_valid`=1 with `din` != 0: load `pending`<=`din` and go to SCAN.
  - `in_valid`=1 with `din`=0: accept and discard the vector, stay in IDLE, produce no output.
- SCAN:
  - `in_ready`=0, `busy`=1, `out_valid`=1.
  - `qout` = index of the highest set bit of `pending`.
  - `out_last`=1 when exactly one bit of `pending` is set.
  - On `out_valid`&`out_ready`: clear bit `qout` of `pending`. If `out_last`=1, go to IDLE; otherwise stay in SCAN.
  - While `out_ready`=0: `pending`, `qout` and `out_last` hold stable.
- `din` is ignored whenever `in_ready`=0.
- `qout`, `out_last` and `out_valid` are combinational from the state and `pending` registers only. There is no combinational path from `in_valid`/`din` or `out_ready` to any output.

## Timing
- Capture at edge k → `out_valid`=1 with the first index from cycle k+1.
- With `out_ready` held at 1, a vector with P set bits yields P consecutive transfers in cycles k+1 … k+P.
- IDLE is re-entered at edge k+P, so `in_ready`=1 in cycle k+P+1. Minimum vector-to-vector spacing is P+1 cycles.
- Zero vector: accepted in one cycle; `in_ready` stays 1.
- Reset during SCAN: the remaining indices are lost. Outputs drop as listed under Operation while `nrst` is low, and the block is in IDLE from the first cycle after the reset edge.
- All-ones vector: emits N-1, N-2, … 0, with `out_last` set only on index 0.

## Configuration
- `PSE_POPCOUNT_EN` defined:
  - Adds the `pop_count` port, a registered count of the set bits in `pending`.
  - Loads popcount(`din`) on capture and decrements by 1 on each output transfer, so it reaches 0 on the IDLE return.
  - It is 0 in IDLE and after reset.
- `PSE_POPCOUNT_EN` undefined: no `pop_count` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset, then `din`=8'b1010_0100 with `in_valid`=1 and `out_ready`=1 → `qout`=7, 5, 2 in three consecutive cycles; `out_last` set only on 2; `in_ready` back to 1 the following cycle.
- `din`=8'h00 with `in_valid`=1 → accepted, `out_valid` stays 0, `in_ready` stays 1.
- `din`=8'h90 with `out_ready` toggled 0,0,1,0,1 → `qout`=7 held for three cycles, then 4 held until accepted; no index skipped or repeated.
- `din`=8'hFF with `out_ready`=1 → 7 down to 0 over 8 cycles; with the macro, `pop_count` reads 8, 7, … 1, then 0.
- `nrst` asserted mid-scan of 8'h0F after index 3 is emitted → next cycle `out_valid`=0, `busy`=0, `in_ready`=1; a new `din`=8'h01 yields `qout`=0 with `out_last`=1.
- In SCAN, drive `in_valid`=1 with `din`=8'hFF → ignored; the original sequence completes unchanged.
